pipe_shifter: RTL and testbench
===============================

Name: pipe_shifter

Overview:
- Parametrised, pipelined shift/rotate unit of width 2**N with a valid/ready handshake on input and output.
- Supersedes the combinational shifter: adds rotate modes, defined behaviour for shift amounts at or above the width, a zero flag, and back-pressure.
- Sits between the operand registers and the result bus of the ALU datapath.
- One log-level per pipeline stage, so clock rate is independent of N.

Parameters:
N, 3, log2 of data width; W = 2**N (default 8 bits)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand set valid
in_ready  out  1  unit accepts operands this cycle
in_a  in  W  data to shift
in_b  in  W  alternate amount source; only in_b[N:0] used
in_c  in  N+1  primary shift amount
in_op  in  4  [3]=rotate group, [2]=amount select (0:in_c, 1:in_b[N:0]), [1:0]=mode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_y  out  W  result
out_zero  out  1  out_y == 0

Behaviour:
- Acceptance: a transfer occurs on an edge where in_valid && in_ready. Output transfer occurs where out_valid && out_ready.
- Global enable: en = !out_valid || out_ready. in_ready = en && !reset. All stages advance only when en=1, otherwise every stage register holds.
- Modes with op[3]=0: 00 SLL, 01 SRL, 10 pass (out_y=in_a), 11 SRA (sign fill from in_a[W-1]).
- Modes with op[3]=1: 00 ROL, 01 ROR, 10 pass, 11 reserved, treated as pass.
- Amount S is N+1 bits.
  - Logical shifts with S >= W: result 0.
  - SRA with S >= W: result is all copies of the sign bit.
  - Rotates use S mod W, i.e. S[N] is ignored.
  - S=0 returns in_a unchanged in every mode.
- Pipeline has N+1 register stages, each with its own valid bit.
  - Stage 0 captures in_a, the decoded mode, S[N-1:0] and a saturate flag (S[N] && !rotate).
  - Stage k (1..N) applies a shift/rotate of 2**(k-1) when amount bit k-1 is set.
  - Saturation is applied at the stage-N input.
  - Stage N drives out_y, out_valid and out_zero.
- Latency: with en held 1, operands accepted on edge E appear on out_y after edge E+N.
  - Throughput is 1 per cycle.
  - Ordering is strict FIFO.
- Bubbles are not compressed. An invalid stage still advances with en. Its data content is don't-care but deterministic.
- out_zero is registered with out_y in the same stage and is valid only while out_valid=1.
- Reset (synchronous, priority over en):
  - All valid bits 0, out_y=0, out_zero=0.
  - In-flight operations are discarded.
  - in_ready=0 during the reset cycle and 1 on the first cycle after.
- Simultaneous accept and emit on the same edge is legal and loses nothing.
- With out_ready=0 and out_valid=1:
  - in_ready=0.
  - out_y, out_zero and out_valid remain stable until the output transfer.

Test Plan:
1. N=3, in_a=0x96, op=0000, in_c=2 -> out_y=0x58, out_zero=0, out_valid rises 3 edges after accept.
2. in_a=0x96, op=0111 (SRA, amount from in_b), in_b=0x03, in_c=7 -> out_y=0xF2. Check that in_c is ignored.
3. Saturation, in_a=0x96:
   - op=0001, in_c=8 -> 0x00, out_zero=1.
   - op=0011, in_c=9 -> 0xFF.
   - op=1000 (ROL), in_c=10 -> 0x5A.
   - op=1001 (ROR), in_c=3 -> 0xD2.
4. Back-pressure:
   - Stream 6 ops back-to-back with out_ready=0 -> pipeline fills, in_ready drops to 0, out_y holds the first result.
   - Raise out_ready -> all 6 results emerge in order, one per cycle, none dropped or duplicated.
5. Reset mid-flight:
   - Assert reset for 1 cycle with 3 ops in flight -> out_valid=0, out_y=0 next cycle, in_ready=1 the cycle after.
   - No stale result ever appears.
6. Pass mode: op=0010 and op=1110 with in_c=5 -> out_y=in_a. Random compare against a reference model for all modes, all S in 0..15, random out_ready.

Source files
------------

// File: rtl/pipe_shifter.sv
// Pipelined shift/rotate unit, one log2 level per stage, with a valid/ready
// handshake on both sides. A single global enable stalls every stage at once,
// so back-pressure never reorders, drops or duplicates results.
module pipe_shifter #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in_a,
  input  logic [2**N-1:0]   in_b,
  input  logic [N:0]        in_c,
  input  logic [3:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_y,
  output logic              out_zero
);

  localparam int          W  = 2**N;
  localparam int unsigned NU = N;

  typedef enum logic [2:0] {
    M_SLL,
    M_SRL,
    M_SRA,
    M_ROL,
    M_ROR,
    M_PASS
  } mode_t;

  // Stage registers 0..N-1; stage N is out_y/out_zero/out_valid.
  logic [W-1:0] sdata  [N];
  mode_t        smode  [N];
  logic [N-1:0] samt   [N];
  logic         ssat   [N];
  logic         svalid [N];

  logic [W-1:0] nxt_data  [N];
  mode_t        nxt_mode  [N];
  logic [N-1:0] nxt_amt   [N];
  logic         nxt_sat   [N];
  logic         nxt_valid [N];

  logic         en;
  logic [N:0]   dec_s;
  mode_t        dec_mode;
  logic [W-1:0] y_pre;
  logic [W-1:0] y_nxt;
  logic         unused_b;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !reset;
  assign unused_b = ^in_b[W-1:N+1];

  // One fixed-distance step; arithmetic right shift keeps the MSB, which is
  // why the final saturation can read the sign from the stage-(N-1) data.
  function automatic logic [W-1:0] step(input mode_t m, input logic [W-1:0] d,
                                        input int unsigned sh);
    logic [W-1:0] r;
    case (m)
      M_SLL:   r = d << sh;
      M_SRL:   r = d >> sh;
      M_SRA:   r = $signed(d) >>> sh;
      M_ROL:   r = (d << sh) | (d >> (W - sh));
      M_ROR:   r = (d >> sh) | (d << (W - sh));
      default: r = d;
    endcase
    return r;
  endfunction

  // Operand decode, per-stage next values and the saturated final result.
  always_comb begin
    dec_s = in_op[2] ? in_b[N:0] : in_c;
    case ({in_op[3], in_op[1:0]})
      3'b000:  dec_mode = M_SLL;
      3'b001:  dec_mode = M_SRL;
      3'b011:  dec_mode = M_SRA;
      3'b100:  dec_mode = M_ROL;
      3'b101:  dec_mode = M_ROR;
      default: dec_mode = M_PASS;
    endcase

    nxt_data[0]  = in_a;
    nxt_mode[0]  = dec_mode;
    nxt_amt[0]   = dec_s[N-1:0];
    nxt_sat[0]   = dec_s[N] && !in_op[3] && (dec_mode != M_PASS);
    nxt_valid[0] = in_valid;

    for (int unsigned k = 1; k < NU; k++) begin
      nxt_data[k]  = samt[k-1][k-1] ? step(smode[k-1], sdata[k-1], 1 << (k-1))
                                    : sdata[k-1];
      nxt_mode[k]  = smode[k-1];
      nxt_amt[k]   = samt[k-1];
      nxt_sat[k]   = ssat[k-1];
      nxt_valid[k] = svalid[k-1];
    end

    y_pre = samt[N-1][N-1] ? step(smode[N-1], sdata[N-1], 1 << (N-1))
                           : sdata[N-1];
    if (ssat[N-1])
      y_nxt = (smode[N-1] == M_SRA) ? {W{sdata[N-1][W-1]}} : '0;
    else
      y_nxt = y_pre;
  end

  // Pipeline registers: reset clears everything, otherwise all stages move on en.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NU; k++) begin
        sdata[k]  <= '0;
        smode[k]  <= M_PASS;
        samt[k]   <= '0;
        ssat[k]   <= 1'b0;
        svalid[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < NU; k++) begin
        sdata[k]  <= nxt_data[k];
        smode[k]  <= nxt_mode[k];
        samt[k]   <= nxt_amt[k];
        ssat[k]   <= nxt_sat[k];
        svalid[k] <= nxt_valid[k];
      end
      out_valid <= svalid[N-1];
      out_y     <= y_nxt;
      out_zero  <= (y_nxt == '0);
    end
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter (N=3, 8-bit): directed vector table, back-pressure
// and reset sequences, and a random stream checked by a scoreboard.
module tb_pipe_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_c;
  logic [3:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [7:0] exp_q[$];
  logic       have_hold = 1'b0;
  logic [7:0] hold_y;
  logic       hold_z;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] c;
    logic [3:0] op;
    logic [7:0] y;
    logic       z;
  } vec_t;

  vec_t vecs[14];

  pipe_shifter #(.N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result computed directly from the amount/mode rules.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] c, input logic [3:0] op);
    int s;
    int av;
    int r;
    s  = op[2] ? int'(b[3:0]) : int'(c);
    av = int'(a);
    case ({op[3], op[1:0]})
      3'b000: r = (s >= 8) ? 0 : (av << s);
      3'b001: r = (s >= 8) ? 0 : (av >> s);
      3'b011: begin
        if (s >= 8) r = a[7] ? 255 : 0;
        else begin
          r = av >> s;
          if (a[7]) r = r | ((255 << (8 - s)) & 255);
        end
      end
      3'b100: begin s = s % 8; r = (av << s) | (av >> (8 - s)); end
      3'b101: begin s = s % 8; r = (av >> s) | (av << (8 - s)); end
      default: r = av;
    endcase
    return r[7:0];
  endfunction

  // Scoreboard/monitor, sampled on the falling edge for the next rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset === 1'b1) begin
      check("reset_in_ready", in_ready, 0);
      exp_q.delete();
      have_hold = 1'b0;
    end else if (reset === 1'b0) begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (have_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", out_y, hold_y);
        check("hold_zero", out_zero, hold_z);
      end
      have_hold = out_valid && !out_ready;
      hold_y    = out_y;
      hold_z    = out_zero;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_y", out_y, e);
          check("sb_zero", out_zero, e == 8'h00);
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_c, in_op));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op;
    in_a  = 8'($urandom);
    in_b  = 8'($urandom);
    in_c  = 4'($urandom_range(15));
    in_op = 4'($urandom_range(15));
  endtask

  task automatic run_one(input vec_t v);
    int lat;
    logic seen;
    in_a = v.a; in_b = v.b; in_c = v.c; in_op = v.op;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("vec_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin tick(); lat++; end
    end
    check("vec_seen", seen, 1);
    check("vec_latency", lat, 3);
    check("vec_y", out_y, v.y);
    check("vec_zero", out_zero, v.z);
    tick();
  endtask

  initial begin
    int acc;
    int cyc;
    int sent;
    int out0;
    logic a_now;
    logic [7:0] first_exp;

    //            a      b      c      op       y      z
    vecs[0]  = '{8'h96, 8'h00, 4'd2,  4'b0000, 8'h58, 1'b0};
    vecs[1]  = '{8'h96, 8'h03, 4'd7,  4'b0111, 8'hF2, 1'b0};
    vecs[2]  = '{8'h96, 8'h00, 4'd8,  4'b0001, 8'h00, 1'b1};
    vecs[3]  = '{8'h96, 8'h00, 4'd9,  4'b0011, 8'hFF, 1'b0};
    vecs[4]  = '{8'h96, 8'h00, 4'd10, 4'b1000, 8'h5A, 1'b0};
    vecs[5]  = '{8'h96, 8'h00, 4'd3,  4'b1001, 8'hD2, 1'b0};
    vecs[6]  = '{8'h96, 8'h00, 4'd5,  4'b0010, 8'h96, 1'b0};
    vecs[7]  = '{8'h96, 8'h00, 4'd5,  4'b1110, 8'h96, 1'b0};
    vecs[8]  = '{8'h96, 8'h00, 4'd0,  4'b0011, 8'h96, 1'b0};
    vecs[9]  = '{8'h01, 8'h00, 4'd7,  4'b0000, 8'h80, 1'b0};
    vecs[10] = '{8'h3C, 8'h00, 4'd3,  4'b1011, 8'h3C, 1'b0};
    vecs[11] = '{8'h40, 8'h00, 4'd8,  4'b0011, 8'h00, 1'b1};
    vecs[12] = '{8'h96, 8'h0F, 4'd0,  4'b1100, 8'h4B, 1'b0};
    vecs[13] = '{8'h96, 8'h00, 4'd4,  4'b0001, 8'h09, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_op = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    for (int i = 0; i < 14; i++) run_one(vecs[i]);

    // Back-pressure: stall the output while streaming six operations.
    out_ready = 1'b0; acc = 0; cyc = 0; out0 = n_out;
    rand_op();
    first_exp = model(in_a, in_b, in_c, in_op);
    in_valid = 1'b1;
    while (cyc < 8) begin
      @(negedge clk);
      a_now = in_valid && in_ready;
      tick(); cyc++;
      if (a_now) begin
        acc++;
        if (acc < 6) rand_op(); else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("bp_accepted", acc, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_first_y", out_y, first_exp);
    tick();
    out_ready = 1'b1; cyc = 0;
    while (acc < 6 && cyc < 30) begin
      @(negedge clk);
      a_now = in_valid && in_ready;
      tick(); cyc++;
      if (a_now) begin
        acc++;
        if (acc < 6) rand_op(); else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 30) begin tick(); cyc++; end
    check("bp_all_accepted", acc, 6);
    check("bp_emitted", n_out - out0, 6);

    // Reset with three operations in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op(); in_valid = 1'b1;
      @(negedge clk);
      check("mr_accept", in_ready, 1);
      tick();
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("mr_in_ready_low", in_ready, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mr_out_valid", out_valid, 0);
    check("mr_out_y", out_y, 0);
    check("mr_in_ready", in_ready, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mr_no_stale", out_valid, 0);
      tick();
    end

    // Random stream with random back-pressure.
    sent = 0; cyc = 0;
    rand_op(); in_valid = 1'b1;
    while (sent < 250 && cyc < 3000) begin
      @(negedge clk);
      a_now = in_valid && in_ready;
      tick(); cyc++;
      if (a_now) sent++;
      if (a_now || !in_valid) begin
        rand_op();
        in_valid = ($urandom_range(3) != 0);
      end
      out_ready = ($urandom_range(3) != 0);
    end
    check("rand_sent", sent, 250);
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 50) begin tick(); cyc++; end
    check("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
